// File: rtl/ub_fifo_dma.sv
// Byte-serial DMA between the host RX/TX byte FIFOs and the unified buffer's FIFO-side port.
// Load mode fills 16-bit words low byte first from RX; store mode drains words into TX.
module ub_fifo_dma #(
    parameter int BUFFER_SIZE     = 1024,
    parameter int FIFO_DATA_WIDTH = 8,
    parameter int ADDRESS_SIZE    = $clog2(BUFFER_SIZE)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       start_i,
    input  logic                       mode_i,
    input  logic [ADDRESS_SIZE-1:0]    base_addr_i,
    input  logic [ADDRESS_SIZE:0]      word_count_i,
    output logic                       busy_o,
    output logic                       xfer_done_o,
    input  logic                       rx_empty_i,
    input  logic [FIFO_DATA_WIDTH-1:0] rx_data_i,
    output logic                       rx_rd_en_o,
    input  logic                       tx_full_i,
    output logic                       tx_wr_en_o,
    output logic [FIFO_DATA_WIDTH-1:0] tx_data_o,
    output logic                       ub_we_o,
    output logic                       ub_re_o,
    output logic                       ub_fifo_en_o,
    output logic                       ub_section_o,
    output logic [ADDRESS_SIZE-1:0]    ub_address_o,
    output logic [FIFO_DATA_WIDTH-1:0] ub_wdata_o,
    input  logic                       ub_done_i,
    input  logic [FIFO_DATA_WIDTH-1:0] ub_rdata_i
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] LD_WAIT  = 3'd1;
    localparam logic [2:0] LD_WRITE = 3'd2;
    localparam logic [2:0] LD_ACK   = 3'd3;
    localparam logic [2:0] ST_READ  = 3'd4;
    localparam logic [2:0] ST_ACK   = 3'd5;
    localparam logic [2:0] ST_PUSH  = 3'd6;
    localparam logic [2:0] FINISH   = 3'd7;

    logic [2:0]                 state_q,   state_d;
    logic                       mode_q,    mode_d;
    logic                       section_q, section_d;
    logic [ADDRESS_SIZE-1:0]    addr_q,    addr_d;
    logic [ADDRESS_SIZE:0]      remain_q,  remain_d;
    logic [FIFO_DATA_WIDTH-1:0] wdata_q,   wdata_d;
    logic [FIFO_DATA_WIDTH-1:0] txdata_q,  txdata_d;
    logic                       advance;

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        section_d  = section_q;
        addr_d     = addr_q;
        remain_d   = remain_q;
        wdata_d    = wdata_q;
        txdata_d   = txdata_q;
        advance    = 1'b0;
        rx_rd_en_o = 1'b0;
        tx_wr_en_o = 1'b0;
        ub_we_o    = 1'b0;
        ub_re_o    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    mode_d    = mode_i;
                    addr_d    = base_addr_i;
                    remain_d  = word_count_i;
                    section_d = 1'b0;
                    if (word_count_i == '0)
                        state_d = FINISH;
                    else
                        state_d = mode_i ? ST_READ : LD_WAIT;
                end
            end
            LD_WAIT: begin
                if (!rx_empty_i) begin
                    rx_rd_en_o = 1'b1;
                    wdata_d    = rx_data_i;
                    state_d    = LD_WRITE;
                end
            end
            LD_WRITE: begin
                ub_we_o = 1'b1;
                state_d = LD_ACK;
            end
            LD_ACK: begin
                if (ub_done_i)
                    advance = 1'b1;
            end
            ST_READ: begin
                ub_re_o = 1'b1;
                state_d = ST_ACK;
            end
            ST_ACK: begin
                if (ub_done_i) begin
                    txdata_d = ub_rdata_i;
                    state_d  = ST_PUSH;
                end
            end
            ST_PUSH: begin
                if (!tx_full_i) begin
                    tx_wr_en_o = 1'b1;
                    advance    = 1'b1;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Low section done: move to the high byte of the same word; otherwise step to the next word.
        if (advance) begin
            if (!section_q) begin
                section_d = 1'b1;
                state_d   = mode_q ? ST_READ : LD_WAIT;
            end else begin
                section_d = 1'b0;
                addr_d    = addr_q + ADDRESS_SIZE'(1);
                remain_d  = remain_q - (ADDRESS_SIZE + 1)'(1);
                if (remain_q == (ADDRESS_SIZE + 1)'(1))
                    state_d = FINISH;
                else
                    state_d = mode_q ? ST_READ : LD_WAIT;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            mode_q    <= 1'b0;
            section_q <= 1'b0;
            addr_q    <= '0;
            remain_q  <= '0;
            wdata_q   <= '0;
            txdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            section_q <= section_d;
            addr_q    <= addr_d;
            remain_q  <= remain_d;
            wdata_q   <= wdata_d;
            txdata_q  <= txdata_d;
        end
    end

    assign busy_o       = (state_q != IDLE);
    assign xfer_done_o  = (state_q == FINISH);
    assign ub_fifo_en_o = ub_we_o | ub_re_o;
    assign ub_section_o = section_q;
    assign ub_address_o = addr_q;
    assign ub_wdata_o   = wdata_q;
    assign tx_data_o    = txdata_q;

endmodule

// File: tb/tb_ub_fifo_dma.sv
// Scoreboard bench for ub_fifo_dma with behavioural models of the unified buffer and RX FIFO.
// Directed transfers push expected writes/pushes into queues; a negedge monitor pops and compares.
module tb_ub_fifo_dma;

    logic        clk = 1'b0;
    logic        rstN = 1'b1;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [9:0]  baseAddr = '0;
    logic [10:0] wordCount = '0;
    logic        busy, xferDone;
    logic        rxEmpty, rxRdEn;
    logic [7:0]  rxData;
    logic        txFull = 1'b0;
    logic        txWrEn;
    logic [7:0]  txData;
    logic        ubWe, ubRe, ubFifoEn, ubSection;
    logic [9:0]  ubAddress;
    logic [7:0]  ubWdata;
    logic        ubDone = 1'b0;
    logic [7:0]  ubRdata = '0;

    int compared   = 0;
    int mismatched = 0;
    int weCount = 0, reCount = 0, popCount = 0, pushCount = 0, doneCount = 0;

    typedef struct {
        logic [9:0] addr;
        logic       sec;
        logic [7:0] data;
    } wrExp_t;

    wrExp_t     expWr[$];
    logic [7:0] expTx[$];

    always #5 clk = ~clk;

    ub_fifo_dma dut (
        .clk_i(clk), .rst_ni(rstN), .start_i(start), .mode_i(mode),
        .base_addr_i(baseAddr), .word_count_i(wordCount),
        .busy_o(busy), .xfer_done_o(xferDone),
        .rx_empty_i(rxEmpty), .rx_data_i(rxData), .rx_rd_en_o(rxRdEn),
        .tx_full_i(txFull), .tx_wr_en_o(txWrEn), .tx_data_o(txData),
        .ub_we_o(ubWe), .ub_re_o(ubRe), .ub_fifo_en_o(ubFifoEn),
        .ub_section_o(ubSection), .ub_address_o(ubAddress), .ub_wdata_o(ubWdata),
        .ub_done_i(ubDone), .ub_rdata_i(ubRdata)
    );

    // Unified buffer model: one-cycle done after each request, byte-lane writes and reads.
    logic [15:0] ubMem [0:1023];
    always @(posedge clk) begin
        ubDone <= ubFifoEn;
        if (ubWe) begin
            if (ubSection) ubMem[ubAddress][15:8] <= ubWdata;
            else           ubMem[ubAddress][7:0]  <= ubWdata;
        end
        if (ubRe)
            ubRdata <= ubSection ? ubMem[ubAddress][15:8] : ubMem[ubAddress][7:0];
    end

    // First-word-fall-through RX FIFO model with monotonic pointers.
    logic [7:0] rxMem [0:63];
    int rxWr = 0;
    int rxRd = 0;
    assign rxEmpty = (rxRd == rxWr);
    assign rxData  = rxMem[rxRd[5:0]];
    always @(posedge clk) begin
        if (rxRdEn && !rxEmpty)
            rxRd <= rxRd + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic pushRx(input logic [7:0] b);
        rxMem[rxWr[5:0]] = b;
        rxWr = rxWr + 1;
    endtask

    task automatic expectWrite(input logic [9:0] a, input logic s, input logic [7:0] d);
        wrExp_t e;
        e.addr = a;
        e.sec  = s;
        e.data = d;
        expWr.push_back(e);
    endtask

    // Monitor: every strobe is compared against the scoreboard queues.
    always @(negedge clk) begin
        if (rstN) begin
            if (ubWe || ubRe || ubFifoEn)
                checkOutput("fifoEn", 32'(ubFifoEn), 32'(ubWe | ubRe));
            if (ubWe) begin
                wrExp_t e;
                weCount++;
                checkOutput("ubWriteQueued", 32'(expWr.size() > 0), 32'd1);
                if (expWr.size() > 0) begin
                    e = expWr.pop_front();
                    checkOutput("ubWrite", 32'({ubAddress, ubSection, ubWdata}), 32'({e.addr, e.sec, e.data}));
                end
            end
            if (ubRe) reCount++;
            if (txWrEn) begin
                pushCount++;
                checkOutput("txPushWhileFull", 32'(txFull), 32'd0);
                checkOutput("txPushQueued", 32'(expTx.size() > 0), 32'd1);
                if (expTx.size() > 0)
                    checkOutput("txByte", 32'(txData), 32'(expTx.pop_front()));
            end
            if (rxRdEn) begin
                popCount++;
                checkOutput("rxPopWhileEmpty", 32'(rxEmpty), 32'd0);
            end
            if (xferDone) doneCount++;
        end
    end

    // Starts one transfer, then scrambles the launch inputs to prove they were latched.
    task automatic applyStimulus(input logic m, input logic [9:0] b, input logic [10:0] n,
                                 input int expCycles, input string name);
        int k;
        @(posedge clk); #1;
        mode = m; baseAddr = b; wordCount = n; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; mode = ~m; baseAddr = 10'h2AA; wordCount = 11'd7;
        k = 0;
        while (1) begin
            @(negedge clk);
            if (k == 0) checkOutput({name, "BusyRise"}, 32'(busy), 32'd1);
            if (xferDone) break;
            k++;
            if (k > 400) begin
                checkOutput({name, "Timeout"}, 32'(k), 32'(expCycles));
                break;
            end
        end
        checkOutput({name, "Cycles"}, 32'(k), 32'(expCycles));
        @(negedge clk);
        checkOutput({name, "BusyFall"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int snapA, snapB, snapC, snapD, rxBase;

        #1 rstN = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("resetOutputs",
                    32'({busy, xferDone, rxRdEn, txWrEn, txData, ubWe, ubRe, ubFifoEn, ubSection}), 32'd0);
        checkOutput("resetAddrData", 32'({ubAddress, ubWdata}), 32'd0);
        @(posedge clk); #1 rstN = 1'b1;

        $display("[TB] load base 0x010 count 2");
        pushRx(8'h11); pushRx(8'h22); pushRx(8'h33); pushRx(8'h44);
        expectWrite(10'h010, 1'b0, 8'h11); expectWrite(10'h010, 1'b1, 8'h22);
        expectWrite(10'h011, 1'b0, 8'h33); expectWrite(10'h011, 1'b1, 8'h44);
        snapA = popCount; snapB = doneCount;
        applyStimulus(1'b0, 10'h010, 11'd2, 12, "load");
        checkOutput("loadPops", 32'(popCount - snapA), 32'd4);
        checkOutput("loadDonePulses", 32'(doneCount - snapB), 32'd1);
        checkOutput("loadMem010", 32'(ubMem[10'h010]), 32'h2211);
        checkOutput("loadMem011", 32'(ubMem[10'h011]), 32'h4433);

        $display("[TB] store base 0x010 count 2");
        expTx.push_back(8'h11); expTx.push_back(8'h22);
        expTx.push_back(8'h33); expTx.push_back(8'h44);
        snapA = pushCount; snapB = reCount; snapC = weCount;
        applyStimulus(1'b1, 10'h010, 11'd2, 12, "store");
        checkOutput("storePushes", 32'(pushCount - snapA), 32'd4);
        checkOutput("storeReads", 32'(reCount - snapB), 32'd4);
        checkOutput("storeNoWrites", 32'(weCount - snapC), 32'd0);

        $display("[TB] load with RX stall");
        pushRx(8'h11);
        expectWrite(10'h020, 1'b0, 8'h11); expectWrite(10'h020, 1'b1, 8'h22);
        expectWrite(10'h021, 1'b0, 8'h33); expectWrite(10'h021, 1'b1, 8'h44);
        rxBase = rxRd;
        fork
            applyStimulus(1'b0, 10'h020, 11'd2, 15, "ldStall");
            begin
                for (int g = 0; g < 50; g++) begin
                    @(posedge clk); #1;
                    if (rxRd == rxBase + 1) break;
                end
                checkOutput("ldStallFirstPop", 32'(rxRd - rxBase), 32'd1);
                snapA = weCount;
                repeat (5) @(posedge clk);
                #1;
                checkOutput("ldStallWrites", 32'(weCount - snapA), 32'd1);
                checkOutput("ldStallBusy", 32'(busy), 32'd1);
                pushRx(8'h22); pushRx(8'h33); pushRx(8'h44);
            end
        join
        checkOutput("ldStallMem020", 32'(ubMem[10'h020]), 32'h2211);
        checkOutput("ldStallMem021", 32'(ubMem[10'h021]), 32'h4433);

        $display("[TB] store with TX full");
        expTx.push_back(8'h11); expTx.push_back(8'h22);
        txFull = 1'b1;
        snapD = pushCount;
        fork
            applyStimulus(1'b1, 10'h020, 11'd1, 8, "stFull");
            begin
                @(posedge clk);
                @(posedge clk);
                repeat (2) @(posedge clk);
                @(negedge clk);
                checkOutput("stFullHold1", 32'(txData), 32'h11);
                @(negedge clk);
                checkOutput("stFullHold2", 32'(txData), 32'h11);
                checkOutput("stFullNoPush", 32'(pushCount - snapD), 32'd0);
                @(posedge clk); #1;
                txFull = 1'b0;
            end
        join
        checkOutput("stFullPushes", 32'(pushCount - snapD), 32'd2);

        $display("[TB] load wrapping at 0x3FF");
        pushRx(8'hA1); pushRx(8'hB2); pushRx(8'hC3); pushRx(8'hD4);
        expectWrite(10'h3FF, 1'b0, 8'hA1); expectWrite(10'h3FF, 1'b1, 8'hB2);
        expectWrite(10'h000, 1'b0, 8'hC3); expectWrite(10'h000, 1'b1, 8'hD4);
        applyStimulus(1'b0, 10'h3FF, 11'd2, 12, "wrap");
        checkOutput("wrapMem3FF", 32'(ubMem[10'h3FF]), 32'hB2A1);
        checkOutput("wrapMem000", 32'(ubMem[10'h000]), 32'hD4C3);

        $display("[TB] zero word count");
        snapA = weCount + reCount + popCount + pushCount; snapB = doneCount;
        applyStimulus(1'b0, 10'h030, 11'd0, 0, "zero");
        checkOutput("zeroStrobes", 32'(weCount + reCount + popCount + pushCount - snapA), 32'd0);
        checkOutput("zeroDone", 32'(doneCount - snapB), 32'd1);

        $display("[TB] reset during LD_ACK");
        pushRx(8'h55); pushRx(8'h66); pushRx(8'h77); pushRx(8'h88);
        expectWrite(10'h040, 1'b0, 8'h55);
        snapA = doneCount; snapB = weCount;
        @(posedge clk); #1;
        mode = 1'b0; baseAddr = 10'h040; wordCount = 11'd2; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #2 rstN = 1'b0;
        #1;
        checkOutput("abortOutputs",
                    32'({busy, xferDone, rxRdEn, txWrEn, txData, ubWe, ubRe, ubFifoEn, ubSection}), 32'd0);
        checkOutput("abortAddrData", 32'({ubAddress, ubWdata}), 32'd0);
        repeat (3) @(posedge clk);
        #1 rstN = 1'b1;
        checkOutput("abortNoDone", 32'(doneCount - snapA), 32'd0);
        checkOutput("abortWrites", 32'(weCount - snapB), 32'd1);
        checkOutput("abortPartial", 32'(ubMem[10'h040][7:0]), 32'h55);

        pushRx(8'h99);
        expectWrite(10'h050, 1'b0, 8'h66); expectWrite(10'h050, 1'b1, 8'h77);
        expectWrite(10'h051, 1'b0, 8'h88); expectWrite(10'h051, 1'b1, 8'h99);
        applyStimulus(1'b0, 10'h050, 11'd2, 12, "afterAbort");
        checkOutput("afterAbortMem050", 32'(ubMem[10'h050]), 32'h7766);
        checkOutput("afterAbortMem051", 32'(ubMem[10'h051]), 32'h9988);

        $display("[TB] start pulsed while busy");
        pushRx(8'hE1); pushRx(8'hF2);
        expectWrite(10'h060, 1'b0, 8'hE1); expectWrite(10'h060, 1'b1, 8'hF2);
        snapA = reCount;
        fork
            applyStimulus(1'b0, 10'h060, 11'd1, 6, "busyStart");
            begin
                repeat (4) @(posedge clk);
                #1;
                start = 1'b1; mode = 1'b1; baseAddr = 10'h100; wordCount = 11'd5;
                @(posedge clk); #1 start = 1'b0;
            end
        join
        checkOutput("busyStartNoReads", 32'(reCount - snapA), 32'd0);
        checkOutput("busyStartMem060", 32'(ubMem[10'h060]), 32'hF2E1);
        repeat (3) @(negedge clk);
        checkOutput("busyStartIdle", 32'(busy), 32'd0);

        checkOutput("expWrDrained", 32'(expWr.size()), 32'd0);
        checkOutput("expTxDrained", 32'(expTx.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        compared++;
        mismatched++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/ub_fifo_dma.md
# ub_fifo_dma

Byte-serial transfer engine between the host byte FIFOs and the unified buffer's FIFO-side port. In load mode it pops bytes from the RX FIFO and writes them into consecutive 16-bit buffer words, low section first. In store mode it reads buffer words section by section and pushes the bytes into the TX FIFO. It sits directly upstream/downstream of `unified_buffer`, driving its `we`/`re`/`fifo_en`/`section`/`address`/`fifo_in` and consuming `done`/`fifo_out`.

## Interface
- `BUFFER_SIZE`, 1024, words in the unified buffer.
- `FIFO_DATA_WIDTH`, 8, byte width; one buffer word = 2 sections.
- `ADDRESS_SIZE`, `$clog2(BUFFER_SIZE)`, buffer address width.
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: launch a transfer; sampled only in IDLE.
- `mode` in 1: 0 = load (RX FIFO→buffer), 1 = store (buffer→TX FIFO); latched at start.
- `base_addr` in ADDRESS_SIZE: first word address; latched at start.
- `word_count` in ADDRESS_SIZE+1: words to move; latched at start.
- `busy` out 1: high in every state except IDLE.
- `xfer_done` out 1: one-cycle pulse at transfer end.
- `rx_empty` in 1: RX FIFO empty (first-word-fall-through).
- `rx_data` in FIFO_DATA_WIDTH: RX head byte, valid when `!rx_empty`.
- `rx_rd_en` out 1: pop RX head this cycle.
- `tx_full` in 1: TX FIFO full.
- `tx_wr_en` out 1: push `tx_data` this cycle.
- `tx_data` out FIFO_DATA_WIDTH: byte to TX FIFO.
- `ub_we`, `ub_re`, `ub_fifo_en` out 1: buffer controls; `ub_fifo_en` = `ub_we | ub_re`. The buffer's `compute_en` is tied 0 at integration.
- `ub_section` out 1: 0 = bits [7:0], 1 = bits [15:8].
- `ub_address` out ADDRESS_SIZE: buffer word address.
- `ub_wdata` out FIFO_DATA_WIDTH: drives buffer `fifo_in`.
- `ub_done` in 1: buffer `done`.
- `ub_rdata` in FIFO_DATA_WIDTH: buffer `fifo_out`.

## Operation
- States: IDLE, LD_WAIT, LD_WRITE, LD_ACK, ST_READ, ST_ACK, ST_PUSH, FINISH.
- IDLE:
  - On `start`, latch `mode`, `base_addr` into the address counter, and `word_count` into the remaining counter. Clear section to 0.
  - If count = 0, go to FINISH. Otherwise go to LD_WAIT (mode 0) or ST_READ (mode 1).
- LD_WAIT: when `!rx_empty`, assert `rx_rd_en` combinationally for that cycle, register `rx_data` into `ub_wdata`, and go to LD_WRITE. Otherwise stay.
- LD_WRITE: `ub_we`=`ub_fifo_en`=1 for exactly this cycle, then go to LD_ACK.
- ST_READ: `ub_re`=`ub_fifo_en`=1 for exactly this cycle, then go to ST_ACK.
- LD_ACK / ST_ACK: wait for `ub_done`.
  - ST_ACK captures `ub_rdata` into `tx_data` on the `ub_done` cycle, then goes to ST_PUSH.
  - LD_ACK advances on `ub_done`.
- ST_PUSH: when `!tx_full`, assert `tx_wr_en` for one cycle and advance. Otherwise hold `tx_data` and stay.
- Advance rule:
  - If section = 0: set section to 1 and return to LD_WAIT/ST_READ.
  - Else: set section to 0, increment the address, decrement the remaining count. If the remaining count becomes 0, go to FINISH; otherwise return.
- Address increments modulo 2^ADDRESS_SIZE: 1023 → 0 with no error.
- FINISH: `xfer_done`=1 for one cycle, then IDLE.
- `start` while busy is ignored. `ub_section`/`ub_address` are stable throughout each request/ack pair.

## Timing
- Reset: state IDLE; all outputs 0, including `ub_address`, `ub_wdata`, `tx_data`, `busy`, `xfer_done`, `rx_rd_en`, `tx_wr_en`.
- Reset asserted mid-transfer aborts immediately. No further buffer/FIFO strobes are issued and no `xfer_done` pulse occurs; a partially written word stays as written.
- Minimum cost with no FIFO stalls and `ub_done` one cycle after request:
  - Load: 3 cycles/byte, 6 cycles/word.
  - Store: 3 cycles/byte, 6 cycles/word.
- Total latency: `start` cycle + 6·N cycles, then `xfer_done` in the following cycle.
- `busy` rises the cycle after `start` is sampled and falls the cycle after `xfer_done`.
- `rx_rd_en` and `tx_wr_en` are never high when `rx_empty`/`tx_full` respectively.

## Test plan
- Load, base 0x010, count 2, RX holds 11,22,33,44 with no stalls:
  - mem[0x010] = 0x2211, mem[0x011] = 0x4433.
  - `xfer_done` pulse 13 cycles after the `start` edge; 4 `rx_rd_en` pulses.
- Store, base 0x010, count 2, after the above:
  - TX receives 11,22,33,44 in order; exactly 4 `tx_wr_en` pulses.
- Stall handling:
  - RX empty for 5 cycles between bytes 1 and 2: FSM holds in LD_WAIT with `ub_we`=0; final memory is identical to the no-stall case.
  - `tx_full` high for 4 cycles: `tx_data` is held and only one push occurs after release.
- Wrap and zero count:
  - Load base 0x3FF, count 2: writes land at 0x3FF then 0x000.
  - count 0: `xfer_done` on the second cycle after `start`, and no strobes at all.
- Abort and ignored start:
  - `rst_n` low during LD_ACK of word 1: all outputs 0 asynchronously, no `xfer_done`; a new `start` after release runs normally.
  - `start` pulsed while busy: no effect.
